// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl:
// hazard sources flow to the controller and pipeline enables flow back.
interface hazard_ctrl_if;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_uses_rs2;
  logic       idex_memread;
  logic [4:0] idex_rd;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_hold;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_memread, idex_rd,
           ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_memread, idex_rd,
           ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush window, memory hold.
// Define HAZARD_PERF_EN to build the saturating stall/flush/hold counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] hold_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } action_e;

  localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

  action_e    state_r;
  action_e    state_nxt_s;
  action_e    action_s;
  logic [1:0] fcnt_r;
  logic [1:0] fcnt_nxt_s;
  logic       load_use_s;

  // Load-use detection; register 0 is never a real producer.
  always_comb begin
    load_use_s = 1'b0;
    if (hz.idex_memread && (hz.idex_rd != 5'd0)) begin
      load_use_s = (hz.idex_rd == hz.ifid_rs1) ||
                   (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Priority action select; HOLD freezes both the flush count and state.
  always_comb begin
    action_s    = ST_RUN;
    state_nxt_s = state_r;
    fcnt_nxt_s  = fcnt_r;
    if (reset) begin
      action_s    = ST_RUN;
      state_nxt_s = ST_RUN;
      fcnt_nxt_s  = 2'd0;
    end else if (hz.mem_busy) begin
      action_s = ST_HOLD;
    end else if (hz.ex_branch_taken) begin
      action_s    = ST_FLUSH;
      state_nxt_s = ST_FLUSH;
      fcnt_nxt_s  = FCNT_LOAD;
    end else if ((state_r == ST_FLUSH) && (fcnt_r != 2'd0)) begin
      action_s    = ST_FLUSH;
      state_nxt_s = ST_FLUSH;
      fcnt_nxt_s  = fcnt_r - 2'd1;
    end else if (load_use_s) begin
      action_s    = ST_STALL;
      state_nxt_s = ST_STALL;
    end else begin
      action_s    = ST_RUN;
      state_nxt_s = ST_RUN;
    end
  end

  // Pipeline enables decoded from the same-cycle action.
  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.pipe_hold   = 1'b0;
    case (action_s)
      ST_RUN: begin
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
      end
      ST_STALL: begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_bubble = 1'b1;
      end
      ST_FLUSH: begin
        hz.ifid_flush  = 1'b1;
        hz.idex_bubble = 1'b1;
      end
      ST_HOLD: begin
        hz.pc_write   = 1'b0;
        hz.ifid_write = 1'b0;
        hz.pipe_hold  = 1'b1;
      end
      default: begin
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
      end
    endcase
  end

  // Action history and flush-window counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
      fcnt_r  <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
    end
  end

  assign state = state_r;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] hold_cnt_r;

  // Saturating per-action event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      hold_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if ((action_s == ST_STALL) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if ((action_s == ST_FLUSH) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
      if ((action_s == ST_HOLD) && (hold_cnt_r != CNT_MAX)) begin
        hold_cnt_r <= hold_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
  assign hold_count  = hold_cnt_r;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
  assign hold_count  = {CNT_W{1'b0}};
`endif

endmodule
